// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: drives imem_addr from the fetch PC and buffers
// {PC, instruction} pairs in a first-word-fall-through FIFO toward IF/ID.
module if_prefetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [PC_W-1:0]            imem_addr,
  input  logic [31:0]                imem_data,
  input  logic                       redirect,
  input  logic [PC_W-1:0]            redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0] r_pc_mem    [DEPTH];
  logic [31:0]     r_instr_mem [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [PC_W-1:0] r_fetch_pc;

  logic            w_pop;
  logic            w_push;
  logic [CW-1:0]   w_count_nxt;

  assign imem_addr = r_fetch_pc;
  assign count     = r_count;
  assign out_valid = (r_count != '0) & ~redirect;
  assign out_pc    = r_pc_mem[r_rd_ptr];
  assign out_instr = r_instr_mem[r_rd_ptr];

  assign w_pop  = out_valid & out_ready;
  // A full queue may still accept a word when the head leaves in the same cycle.
  assign w_push = ~redirect & ((r_count < CW'(DEPTH)) | w_pop);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]    <= '0;
        r_instr_mem[i] <= '0;
      end
    end else if (redirect) begin
      // Wrong-path entries are abandoned in place; the empty count hides them.
      r_fetch_pc <= {redirect_pc[PC_W-1:2], 2'b00};
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
        r_instr_mem[r_wr_ptr] <= imem_data;
        r_wr_ptr              <= r_wr_ptr + 1'b1;
        r_fetch_pc            <= r_fetch_pc + PC_W'(4);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: instruction memory returns addr|0x13000000.
module tb_if_prefetch_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_data;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [31:0]     out_instr;
  logic [2:0]      count;

  int n_tests = 0;
  int n_fail  = 0;

  if_prefetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr), .count(count)
  );

  always #5 clk = ~clk;

  assign imem_data = imem_addr[31:0] | 32'h1300_0000;

  // Inputs change on the falling edge; outputs are inspected there as well.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = ready;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    tick();
    tick();
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_tests++; if (out_pc !== 64'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", out_pc); end
    n_tests++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", out_instr); end
    n_tests++; if (imem_addr !== 64'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", imem_addr); end
    reset = 1'b0; out_ready = 1'b1;
    tick();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid got %b want 1", out_valid); end
    for (int k = 0; k < 4; k++) begin
      if (k != 0) tick();
      n_tests++; if (out_pc !== 64'(4*k)) begin n_fail++; $display("FAIL stream_pc[%0d] got %h want %h", k, out_pc, 64'(4*k)); end
      n_tests++; if (out_instr !== (32'h1300_0000 | 32'(4*k))) begin n_fail++; $display("FAIL stream_instr[%0d] got %h want %h", k, out_instr, 32'h1300_0000 | 32'(4*k)); end
      n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL stream_count[%0d] got %0d want 1", k, count); end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    for (int c = 1; c <= 6; c++) begin
      int exp_cnt;
      tick();
      exp_cnt = (c < 4) ? c : 4;
      n_tests++; if (count !== 3'(exp_cnt)) begin n_fail++; $display("FAIL bp_count[%0d] got %0d want %0d", c, count, exp_cnt); end
      n_tests++; if (imem_addr !== 64'(4*exp_cnt)) begin n_fail++; $display("FAIL bp_addr[%0d] got %h want %h", c, imem_addr, 64'(4*exp_cnt)); end
      n_tests++; if (out_pc !== 64'h0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_head[%0d] got pc=%h v=%b want pc=0 v=1", c, out_pc, out_valid); end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_tests++; if (out_valid !== 1'b1 || out_pc !== 64'(4*k)) begin n_fail++; $display("FAIL drain_pc[%0d] got pc=%h v=%b want pc=%h v=1", k, out_pc, out_valid, 64'(4*k)); end
      n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL drain_count[%0d] got %0d want 4", k, count); end
      tick();
    end
  endtask

  task automatic test_redirect_flush();
    do_reset(1'b0);
    for (int c = 0; c < 4; c++) tick();
    n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL flush_full got %0d want 4", count); end
    redirect = 1'b1; redirect_pc = 64'h100;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid_in_redirect got %b want 0", out_valid); end
    tick();
    redirect = 1'b0; out_ready = 1'b1;
    #1;
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count got %0d want 0", count); end
    n_tests++; if (imem_addr !== 64'h100) begin n_fail++; $display("FAIL flush_addr got %h want 100", imem_addr); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty_valid got %b want 0", out_valid); end
    tick();
    n_tests++; if (out_valid !== 1'b1 || out_pc !== 64'h100) begin n_fail++; $display("FAIL flush_first got pc=%h v=%b want pc=100 v=1", out_pc, out_valid); end
    tick();
    n_tests++; if (out_pc !== 64'h104) begin n_fail++; $display("FAIL flush_second got %h want 104", out_pc); end
  endtask

  task automatic test_redirect_align();
    out_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 64'h203;
    tick();
    redirect = 1'b0;
    #1;
    n_tests++; if (imem_addr !== 64'h200) begin n_fail++; $display("FAIL align_addr got %h want 200", imem_addr); end
    tick();
    n_tests++; if (out_pc !== 64'h200 || out_instr !== 32'h1300_0200) begin n_fail++; $display("FAIL align_head got pc=%h instr=%h want 200/13000200", out_pc, out_instr); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 64'h40;
    tick();
    redirect_pc = 64'h80;
    tick();
    redirect = 1'b0;
    #1;
    n_tests++; if (count !== 3'd0 || imem_addr !== 64'h80) begin n_fail++; $display("FAIL b2b_state got cnt=%0d addr=%h want 0/80", count, imem_addr); end
    tick();
    n_tests++; if (out_valid !== 1'b1 || out_pc !== 64'h80) begin n_fail++; $display("FAIL b2b_first got pc=%h v=%b want 80/1", out_pc, out_valid); end
  endtask

  task automatic test_reset_redirect();
    out_ready = 1'b0;
    tick(); tick();
    reset = 1'b1; redirect = 1'b1; redirect_pc = 64'h300;
    tick();
    reset = 1'b0; redirect = 1'b0;
    #1;
    n_tests++; if (imem_addr !== 64'h0) begin n_fail++; $display("FAIL rstredir_addr got %h want 0", imem_addr); end
    n_tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rstredir_empty got cnt=%0d v=%b want 0/0", count, out_valid); end
  endtask

  task automatic test_reset_midstream();
    do_reset(1'b0);
    tick(); tick(); tick();
    n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL mid_pre_count got %0d want 3", count); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_empty got cnt=%0d v=%b want 0/0", count, out_valid); end
    n_tests++; if (out_pc !== 64'h0 || imem_addr !== 64'h0) begin n_fail++; $display("FAIL mid_pc got pc=%h addr=%h want 0/0", out_pc, imem_addr); end
  endtask

  task automatic test_pc_wrap();
    logic [PC_W-1:0] exp_pc [4];
    exp_pc[0] = 64'hFFFF_FFFF_FFFF_FFF8;
    exp_pc[1] = 64'hFFFF_FFFF_FFFF_FFFC;
    exp_pc[2] = 64'h0;
    exp_pc[3] = 64'h4;
    out_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
    tick();
    redirect = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++; if (out_valid !== 1'b1 || out_pc !== exp_pc[k]) begin n_fail++; $display("FAIL wrap_pc[%0d] got pc=%h v=%b want %h", k, out_pc, out_valid, exp_pc[k]); end
      n_tests++; if (out_instr !== (exp_pc[k][31:0] | 32'h1300_0000)) begin n_fail++; $display("FAIL wrap_instr[%0d] got %h want %h", k, out_instr, exp_pc[k][31:0] | 32'h1300_0000); end
    end
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_backpressure();
    test_redirect_flush();
    test_redirect_align();
    test_back_to_back();
    test_reset_redirect();
    test_reset_midstream();
    test_pc_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
